// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module  : vga_timing_pkg
// Purpose : Video mode constants and blanking/total helpers for vga_timing_gen.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    // 640x480@60, 25.175 MHz pixel clock, negative syncs
    localparam int   c_vga640_h_front   = 16;
    localparam int   c_vga640_h_sync    = 96;
    localparam int   c_vga640_h_back    = 48;
    localparam int   c_vga640_h_act     = 640;
    localparam int   c_vga640_v_front   = 10;
    localparam int   c_vga640_v_sync    = 2;
    localparam int   c_vga640_v_back    = 33;
    localparam int   c_vga640_v_act     = 480;
    localparam logic c_vga640_hs_active = 1'b0;
    localparam logic c_vga640_vs_active = 1'b0;

    // 800x600@60, 40 MHz pixel clock, positive syncs
    localparam int   c_vga800_h_front   = 40;
    localparam int   c_vga800_h_sync    = 128;
    localparam int   c_vga800_h_back    = 88;
    localparam int   c_vga800_h_act     = 800;
    localparam int   c_vga800_v_front   = 1;
    localparam int   c_vga800_v_sync    = 4;
    localparam int   c_vga800_v_back    = 23;
    localparam int   c_vga800_v_act     = 600;
    localparam logic c_vga800_hs_active = 1'b1;
    localparam logic c_vga800_vs_active = 1'b1;

    // Polarity-free raw timing flags carried down the alignment delay line
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } raw_t;

    function automatic int blank_len(input int front, input int sync, input int back);
        return front + sync + back;
    endfunction

    function automatic int total_len(input int front, input int sync, input int back,
                                     input int act);
        return blank_len(front, sync, back) + act;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
// ============================================================================
// Module  : vga_delay_line
// Purpose : WIDTH x DEPTH shift register with synchronous clear; DEPTH=0 is a wire.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign dout = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module  : vga_timing_gen
// Purpose : Parametrised VGA raster timing generator with host-latency aligned outputs.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_FRONT   = c_vga640_h_front,
    parameter int   H_SYNC    = c_vga640_h_sync,
    parameter int   H_BACK    = c_vga640_h_back,
    parameter int   H_ACT     = c_vga640_h_act,
    parameter int   V_FRONT   = c_vga640_v_front,
    parameter int   V_SYNC    = c_vga640_v_sync,
    parameter int   V_BACK    = c_vga640_v_back,
    parameter int   V_ACT     = c_vga640_v_act,
    parameter logic HS_ACTIVE = c_vga640_hs_active,
    parameter logic VS_ACTIVE = c_vga640_vs_active,
    parameter int   COLOR_W   = 10,
    parameter int   CNT_W     = 11,
    parameter int   PIX_LAT   = 1
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic               oRequest,
    output logic [CNT_W-1:0]   oCurrent_X,
    output logic [CNT_W-1:0]   oCurrent_Y,
    output logic               oLine_Start,
    output logic               oFrame_Start,
    output logic [7:0]         oFrame_Cnt,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_HS,
    output logic               oVGA_VS,
    output logic               oVGA_BLANK,
    output logic               oVGA_SYNC,
    output logic               oVGA_CLOCK
);

    localparam int c_h_blank = blank_len(H_FRONT, H_SYNC, H_BACK);
    localparam int c_h_total = total_len(H_FRONT, H_SYNC, H_BACK, H_ACT);
    localparam int c_v_blank = blank_len(V_FRONT, V_SYNC, V_BACK);
    localparam int c_v_total = total_len(V_FRONT, V_SYNC, V_BACK, V_ACT);

    localparam logic [CNT_W-1:0] c_h_last     = CNT_W'(c_h_total - 1);
    localparam logic [CNT_W-1:0] c_v_last     = CNT_W'(c_v_total - 1);
    localparam logic [CNT_W-1:0] c_h_act_from = CNT_W'(c_h_blank);
    localparam logic [CNT_W-1:0] c_v_act_from = CNT_W'(c_v_blank);
    localparam logic [CNT_W-1:0] c_hs_from    = CNT_W'(H_FRONT);
    localparam logic [CNT_W-1:0] c_hs_to      = CNT_W'(H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] c_vs_from    = CNT_W'(V_FRONT);
    localparam logic [CNT_W-1:0] c_vs_to      = CNT_W'(V_FRONT + V_SYNC);

    logic [CNT_W-1:0] r_h_cont;
    logic [CNT_W-1:0] r_v_cont;
    logic [7:0]       r_frame_cnt;
    logic             w_h_last;
    logic             w_v_last;
    raw_t             w_raw;
    raw_t             w_raw_dly;

    assign w_h_last = (r_h_cont == c_h_last);
    assign w_v_last = (r_v_cont == c_v_last);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_h_cont    <= '0;
            r_v_cont    <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_h_cont <= w_h_last ? '0 : r_h_cont + CNT_W'(1);
            if (w_h_last) begin
                r_v_cont <= w_v_last ? '0 : r_v_cont + CNT_W'(1);
                if (w_v_last) begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

    // Stage 0: flags and coordinates for the current counter position
    assign w_raw.hs  = (r_h_cont >= c_hs_from) && (r_h_cont < c_hs_to);
    assign w_raw.vs  = (r_v_cont >= c_vs_from) && (r_v_cont < c_vs_to);
    assign w_raw.act = (r_h_cont >= c_h_act_from) && (r_v_cont >= c_v_act_from);

    assign oRequest     = w_raw.act;
    assign oCurrent_X   = w_raw.act ? (r_h_cont - c_h_act_from) : '0;
    assign oCurrent_Y   = w_raw.act ? (r_v_cont - c_v_act_from) : '0;
    assign oLine_Start  = w_raw.act && (r_h_cont == c_h_act_from);
    assign oFrame_Start = oLine_Start && (r_v_cont == c_v_act_from);
    assign oFrame_Cnt   = r_frame_cnt;

    // Holds the flags back until the host's colour for that position arrives
    vga_delay_line #(
        .WIDTH ($bits(raw_t)),
        .DEPTH (PIX_LAT)
    ) u_align (
        .clk  (iCLK),
        .rst  (iRST),
        .din  (w_raw),
        .dout (w_raw_dly)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oVGA_HS    <= ~HS_ACTIVE;
            oVGA_VS    <= ~VS_ACTIVE;
            oVGA_BLANK <= 1'b0;
            oVGA_R     <= '0;
            oVGA_G     <= '0;
            oVGA_B     <= '0;
        end else begin
            oVGA_HS    <= w_raw_dly.hs ? HS_ACTIVE : ~HS_ACTIVE;
            oVGA_VS    <= w_raw_dly.vs ? VS_ACTIVE : ~VS_ACTIVE;
            oVGA_BLANK <= w_raw_dly.act;
            oVGA_R     <= w_raw_dly.act ? iRed   : '0;
            oVGA_G     <= w_raw_dly.act ? iGreen : '0;
            oVGA_B     <= w_raw_dly.act ? iBlue  : '0;
        end
    end

    assign oVGA_SYNC  = 1'b1;
    assign oVGA_CLOCK = ~iCLK;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module  : tb_vga_timing_gen
// Purpose : Self-checking bench for vga_timing_gen on reduced-size video modes.
// Rev     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vga_timing_gen;

    // Mode A: H 2/3/2/8 (total 15, blank 7), V 1/2/1/4 (total 8, blank 4), 120 cycles/frame
    // Mode B: H 1/2/1/6 (total 10, blank 4), V 1/1/1/3 (total 6, blank 3), 60 cycles/frame
    localparam int CW     = 11;
    localparam int COL    = 10;
    localparam int NVEC   = 17;
    localparam int N_RUN  = 257 * 120 + 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [COL-1:0] k_red   = 10'h155;
    logic [COL-1:0] k_green = 10'h0AA;
    logic [COL-1:0] k_blue  = 10'h3C3;
    logic [COL-1:0] b_red   = 10'h2AA;
    logic [COL-1:0] b_zero  = '0;

    logic           a_req, a_ls, a_fs, a_hs, a_vs, a_bl, a_sync, a_clock;
    logic [CW-1:0]  a_x, a_y;
    logic [7:0]     a_fcnt;
    logic [COL-1:0] a_r, a_g, a_b;

    logic           b_req, b_ls, b_fs, b_hs, b_vs, b_bl, b_sync, b_clock;
    logic [CW-1:0]  b_x, b_y;
    logic [7:0]     b_fcnt;
    logic [COL-1:0] b_r, b_g, b_b;

    logic           c_req, c_ls, c_fs, c_hs, c_vs, c_bl, c_sync, c_clock;
    logic [CW-1:0]  c_x, c_y;
    logic [7:0]     c_fcnt;
    logic [COL-1:0] c_r, c_g, c_b;

    vga_timing_gen #(
        .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .H_ACT(8),
        .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .V_ACT(4),
        .HS_ACTIVE(1'b0), .VS_ACTIVE(1'b0), .COLOR_W(COL), .CNT_W(CW), .PIX_LAT(1)
    ) u_dut_a (
        .iCLK(clk), .iRST(rst), .iRed(k_red), .iGreen(k_green), .iBlue(k_blue),
        .oRequest(a_req), .oCurrent_X(a_x), .oCurrent_Y(a_y), .oLine_Start(a_ls),
        .oFrame_Start(a_fs), .oFrame_Cnt(a_fcnt), .oVGA_R(a_r), .oVGA_G(a_g), .oVGA_B(a_b),
        .oVGA_HS(a_hs), .oVGA_VS(a_vs), .oVGA_BLANK(a_bl), .oVGA_SYNC(a_sync),
        .oVGA_CLOCK(a_clock)
    );

    vga_timing_gen #(
        .H_FRONT(1), .H_SYNC(2), .H_BACK(1), .H_ACT(6),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_ACT(3),
        .HS_ACTIVE(1'b1), .VS_ACTIVE(1'b1), .COLOR_W(COL), .CNT_W(CW), .PIX_LAT(3)
    ) u_dut_b (
        .iCLK(clk), .iRST(rst), .iRed(b_red), .iGreen(b_zero), .iBlue(b_zero),
        .oRequest(b_req), .oCurrent_X(b_x), .oCurrent_Y(b_y), .oLine_Start(b_ls),
        .oFrame_Start(b_fs), .oFrame_Cnt(b_fcnt), .oVGA_R(b_r), .oVGA_G(b_g), .oVGA_B(b_b),
        .oVGA_HS(b_hs), .oVGA_VS(b_vs), .oVGA_BLANK(b_bl), .oVGA_SYNC(b_sync),
        .oVGA_CLOCK(b_clock)
    );

    vga_timing_gen #(
        .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .H_ACT(8),
        .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .V_ACT(4),
        .HS_ACTIVE(1'b0), .VS_ACTIVE(1'b0), .COLOR_W(COL), .CNT_W(CW), .PIX_LAT(0)
    ) u_dut_c (
        .iCLK(clk), .iRST(rst), .iRed(k_red), .iGreen(k_green), .iBlue(k_blue),
        .oRequest(c_req), .oCurrent_X(c_x), .oCurrent_Y(c_y), .oLine_Start(c_ls),
        .oFrame_Start(c_fs), .oFrame_Cnt(c_fcnt), .oVGA_R(c_r), .oVGA_G(c_g), .oVGA_B(c_b),
        .oVGA_HS(c_hs), .oVGA_VS(c_vs), .oVGA_BLANK(c_bl), .oVGA_SYNC(c_sync),
        .oVGA_CLOCK(c_clock)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int cyc, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // Mode A output-register flags at cycle n after release for a given latency
    function automatic void model_a(input int n, input int lat,
                                    output int hs, output int vs, output int bl);
        int p, h, v;
        if (n < lat + 1) begin
            hs = 1; vs = 1; bl = 0;
        end else begin
            p  = (n - lat - 1) % 120;
            h  = p % 15;
            v  = p / 15;
            hs = (h >= 2 && h < 5) ? 0 : 1;
            vs = (v >= 1 && v < 3) ? 0 : 1;
            bl = (h >= 7 && v >= 4) ? 1 : 0;
        end
    endfunction

    typedef struct {
        int cyc;
        int req; int x; int y; int ls; int fs; int fcnt;
        int hs;  int vs; int bl;
    } vec_t;

    vec_t tbl [NVEC];

    initial begin
        int ti;
        int e_hs, e_vs, e_bl;
        int a_hs_run, a_vs_run, b_hs_run, b_vs_run, b_k;
        logic a_prev_hs, a_prev_vs, b_prev_hs, b_prev_vs;
        int hist_req [4];
        int hist_x [4];
        int found, a_first_fs, b_first_fs, a_bl_early;

        //          cyc  req x  y  ls fs cnt hs vs bl
        tbl[0]  = '{  0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[1]  = '{  4, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[2]  = '{  6, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{  7, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[4]  = '{ 16, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[5]  = '{ 17, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[6]  = '{ 46, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[7]  = '{ 47, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[8]  = '{ 67, 1, 0, 0, 1, 1, 0, 1, 1, 0};
        tbl[9]  = '{ 68, 1, 1, 0, 0, 0, 0, 1, 1, 0};
        tbl[10] = '{ 69, 1, 2, 0, 0, 0, 0, 1, 1, 1};
        tbl[11] = '{ 75, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        tbl[12] = '{ 79, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[13] = '{ 82, 1, 0, 1, 1, 0, 0, 1, 1, 0};
        tbl[14] = '{119, 1, 7, 3, 0, 0, 0, 1, 1, 1};
        tbl[15] = '{120, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        tbl[16] = '{187, 1, 0, 0, 1, 1, 1, 1, 1, 0};

        for (int i = 0; i < 4; i++) begin
            hist_req[i] = 0;
            hist_x[i]   = 0;
        end

        // Reset held for three edges; everything must sit at its idle level
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_a_hs", -1, a_hs, 1);
            check("rst_a_vs", -1, a_vs, 1);
            check("rst_a_blank", -1, a_bl, 0);
            check("rst_a_rgb", -1, {a_r, a_g, a_b}, 0);
            check("rst_a_req", -1, {a_req, a_ls, a_fs}, 0);
            check("rst_a_fcnt", -1, a_fcnt, 0);
            check("rst_b_syncs", -1, {b_hs, b_vs}, 0);
            check("rst_b_blank_r", -1, {b_bl, b_r}, 0);
            check("rst_c_flags", -1, {c_hs, c_vs, c_bl}, 3'b110);
        end
        rst = 1'b0;

        ti = 0;
        a_hs_run = 0; a_vs_run = 0; b_hs_run = 0; b_vs_run = 0; b_k = 0;
        a_prev_hs = 1'b1; a_prev_vs = 1'b1; b_prev_hs = 1'b0; b_prev_vs = 1'b0;

        for (int n = 0; n < N_RUN; n++) begin
            // Host model for B: colour for X requested three cycles ago, junk otherwise
            b_red = (hist_req[(n + 1) % 4] != 0) ? COL'(hist_x[(n + 1) % 4]) : 10'h2AA;
            hist_req[n % 4] = int'(b_req);
            hist_x[n % 4]   = int'(b_x);

            if (n == 0) begin
                check("a_sync_const", n, a_sync, 1);
                check("a_clock_inv", n, a_clock, 1);
            end

            if (ti < NVEC && tbl[ti].cyc == n) begin
                check("tbl_req", n, a_req, tbl[ti].req);
                check("tbl_x", n, a_x, tbl[ti].x);
                check("tbl_y", n, a_y, tbl[ti].y);
                check("tbl_line_start", n, a_ls, tbl[ti].ls);
                check("tbl_frame_start", n, a_fs, tbl[ti].fs);
                check("tbl_frame_cnt", n, a_fcnt, tbl[ti].fcnt);
                check("tbl_hs", n, a_hs, tbl[ti].hs);
                check("tbl_vs", n, a_vs, tbl[ti].vs);
                check("tbl_blank", n, a_bl, tbl[ti].bl);
                check("tbl_rgb", n, {a_r, a_g, a_b},
                      (tbl[ti].bl != 0) ? {k_red, k_green, k_blue} : 30'h0);
                ti++;
            end

            // A: sync run lengths and HS phase within the line
            if (a_prev_hs && !a_hs) check("a_hs_phase", n, n % 15, 4);
            if (!a_prev_hs && a_hs) begin
                check("a_hs_width", n, a_hs_run, 3);
                a_hs_run = 0;
            end
            if (!a_hs) a_hs_run++;
            if (!a_prev_vs && a_vs) begin
                check("a_vs_width", n, a_vs_run, 30);
                a_vs_run = 0;
            end
            if (!a_vs) a_vs_run++;
            a_prev_hs = a_hs;
            a_prev_vs = a_vs;

            if ((n > 0 && n % 120 == 0) || n % 120 == 119)
                check("a_frame_cnt", n, a_fcnt, (n / 120) % 256);

            // C: zero-latency alignment against the position model
            model_a(n, 0, e_hs, e_vs, e_bl);
            check("c_flags", n, {c_hs, c_vs, c_bl}, {e_hs[0], e_vs[0], e_bl[0]});
            check("c_red", n, c_r, (e_bl != 0) ? k_red : 10'h0);

            // B: colour stream is 0..5 on consecutive BLANK-high cycles, 0 otherwise
            if (b_bl) begin
                check("b_red_seq", n, b_r, b_k);
                b_k = (b_k + 1) % 6;
            end else begin
                check("b_red_blank", n, b_r, 0);
            end
            if (b_prev_hs && !b_hs) begin
                check("b_hs_width", n, b_hs_run, 2);
                b_hs_run = 0;
            end
            if (b_hs) b_hs_run++;
            if (b_prev_vs && !b_vs) begin
                check("b_vs_width", n, b_vs_run, 10);
                b_vs_run = 0;
            end
            if (b_vs) b_vs_run++;
            b_prev_hs = b_hs;
            b_prev_vs = b_vs;
            if (n % 60 == 59) check("b_last_req", n, {b_req, b_x, b_y}, {1'b1, 11'd5, 11'd2});
            if (n % 60 == 34) check("b_frame_start", n, {b_fs, b_x, b_y}, {1'b1, 11'd0, 11'd0});

            @(negedge clk);
        end
        check("tbl_all_applied", N_RUN, ti, NVEC);

        // Mid-frame reset: pick an active pixel of A (X=3, Y=1)
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            if (a_req && a_x == 11'd3 && a_y == 11'd1) found = 1;
            else @(negedge clk);
        end
        check("mid_find", 0, found, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_a_syncs", 0, {a_hs, a_vs, a_bl}, 3'b110);
        check("mid_a_rgb", 0, {a_r, a_g, a_b}, 0);
        check("mid_a_stage0", 0, {a_req, a_ls, a_fs, a_x, a_y}, 0);
        check("mid_a_fcnt", 0, a_fcnt, 0);
        check("mid_b_flags", 0, {b_hs, b_vs, b_bl, b_r}, 0);
        check("mid_c_flags", 0, {c_hs, c_vs, c_bl}, 3'b110);
        rst = 1'b0;

        a_first_fs = -1; b_first_fs = -1; a_bl_early = 0;
        for (int n = 0; n < 200 && a_first_fs < 0; n++) begin
            if (a_bl) a_bl_early++;
            if (a_fs && a_first_fs < 0) a_first_fs = n;
            if (b_fs && b_first_fs < 0) b_first_fs = n;
            @(negedge clk);
        end
        check("mid_a_fs_delay", 0, a_first_fs, 67);
        check("mid_b_fs_delay", 0, b_first_fs, 34);
        check("mid_no_stale_blank", 0, a_bl_early, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
